// File: rtl/exram_portb_arbiter.sv
// Round-robin arbiter sharing EXRAM port B between the display fetch engine
// (requester 0) and the host loader (requester 1), with in-order tagged read return.
module exram_portb_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned READ_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] address_b,
    output logic [DW-1:0] data_b,
    output logic          wren_b,
    input  logic [DW-1:0] q_b
);

    localparam int unsigned DEPTH = READ_LAT + 1;

    logic             last;
    logic [DEPTH-1:0] tag_vld;
    logic [DEPTH-1:0] tag_id;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_data;
    logic             win_we;
    logic             push_rd;

    // Grant: on a tie the requester not served last wins; nothing granted in reset.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (!reset) begin
            gnt0 = req0 & (~req1 | last);
            gnt1 = req1 & (~req0 | ~last);
        end
        win_addr = gnt1 ? addr1  : addr0;
        win_data = gnt1 ? wdata1 : wdata0;
        win_we   = gnt1 ? we1    : we0;
        push_rd  = (gnt0 | gnt1) & ~win_we;
    end

    // Port-B drive, round-robin history and read tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            address_b <= '0;
            data_b    <= '0;
            wren_b    <= 1'b0;
            tag_vld   <= '0;
            tag_id    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
        end else begin
            tag_vld <= {tag_vld[DEPTH-2:0], push_rd};
            tag_id  <= {tag_id[DEPTH-2:0], gnt1};
            rvalid0 <= tag_vld[DEPTH-1] & ~tag_id[DEPTH-1];
            rvalid1 <= tag_vld[DEPTH-1] & tag_id[DEPTH-1];
            if (tag_vld[DEPTH-1]) begin
                rdata <= q_b;
            end
            wren_b <= 1'b0;
            if (gnt0 | gnt1) begin
                last      <= gnt1;
                address_b <= win_addr;
                data_b    <= win_data;
                wren_b    <= win_we;
            end
        end
    end

endmodule

// File: tb/tb_exram_portb_arbiter.sv
// Bench for exram_portb_arbiter: EXRAM model, transaction-level reference model
// with per-cycle comparison, directed scenarios and randomized traffic.
module tb_exram_portb_arbiter;

    localparam int unsigned AW       = 16;
    localparam int unsigned DW       = 16;
    localparam int unsigned READ_LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, wren_b;
    logic [DW-1:0] rdata, data_b, q_b;
    logic [AW-1:0] address_b;

    // Second instance built with a 3-edge read latency.
    logic          r3_req;
    logic [AW-1:0] r3_addr;
    logic          g0_3, g1_3, rv0_3, rv1_3, wren_3;
    logic [DW-1:0] rdata_3, data_3, q_3;
    logic [AW-1:0] addr_3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exram_portb_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b)
    );

    exram_portb_arbiter #(.AW(AW), .DW(DW), .READ_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req0(1'b0), .we0(1'b0), .addr0('0), .wdata0('0), .gnt0(g0_3), .rvalid0(rv0_3),
        .req1(r3_req), .we1(1'b0), .addr1(r3_addr), .wdata1('0), .gnt1(g1_3), .rvalid1(rv1_3),
        .rdata(rdata_3), .address_b(addr_3), .data_b(data_3), .wren_b(wren_3), .q_b(q_3)
    );

    // EXRAM port B: address sampled on an edge, data valid READ_LAT edges later.
    logic [DW-1:0] mem    [0:65535];
    logic [DW-1:0] shadow [0:65535];
    logic [DW-1:0] qpipe  [0:READ_LAT-1];
    logic [DW-1:0] qpipe3 [0:2];

    always @(posedge clk) begin
        for (int i = READ_LAT - 1; i > 0; i--) qpipe[i] <= qpipe[i-1];
        qpipe[0] <= mem[address_b];
        if (wren_b === 1'b1) mem[address_b] = data_b;
        qpipe3[2] <= qpipe3[1];
        qpipe3[1] <= qpipe3[0];
        qpipe3[0] <= addr_3 ^ 16'hA5A5;
    end
    assign q_b = qpipe[READ_LAT-1];
    assign q_3 = qpipe3[2];

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i ^ (i << 5) ^ 32'h5A5A);
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        mem[16]    = 16'hBEEF;
        shadow[16] = 16'hBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transactions accepted in order, reads answered from a shadow
    // memory at their due edge, port-B state is whatever the last acceptance left.
    typedef struct {
        int unsigned   due;
        bit            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    int unsigned   edge_n  = 0;
    bit            m_valid = 0;
    bit            m_last;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, e_rdata;
    bit            e_wren, e_rv0, e_rv1;

    function automatic int winner();
        if (reset || !m_valid) return -1;
        if (req0 && req1) return m_last ? 0 : 1;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin : model_p
        int  w;
        rd_t r;
        edge_n++;
        if (reset) begin
            m_valid = 1;
            m_last  = 1;
            e_addr  = '0;
            e_data  = '0;
            e_wren  = 0;
            e_rdata = '0;
            e_rv0   = 0;
            e_rv1   = 0;
            pend.delete();
        end else if (m_valid) begin
            w     = winner();
            e_rv0 = 0;
            e_rv1 = 0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                r = pend.pop_front();
                if (r.id) e_rv1 = 1; else e_rv0 = 1;
                e_rdata = r.data;
            end
            e_wren = 0;
            if (w >= 0) begin
                m_last = (w == 1);
                e_addr = (w == 1) ? addr1  : addr0;
                e_data = (w == 1) ? wdata1 : wdata0;
                e_wren = (w == 1) ? we1    : we0;
                if (e_wren) shadow[e_addr] = e_data;
                else pend.push_back('{due: edge_n + READ_LAT + 1, id: (w == 1), data: shadow[e_addr]});
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp_p
        int w;
        if (m_valid) begin
            w = winner();
            chk("gnt0",      32'(gnt0),      32'(w == 0));
            chk("gnt1",      32'(gnt1),      32'(w == 1));
            chk("address_b", 32'(address_b), 32'(e_addr));
            chk("data_b",    32'(data_b),    32'(e_data));
            chk("wren_b",    32'(wren_b),    32'(e_wren));
            chk("rvalid0",   32'(rvalid0),   32'(e_rv0));
            chk("rvalid1",   32'(rvalid1),   32'(e_rv1));
            chk("rdata",     32'(rdata),     32'(e_rdata));
        end
    end

    // Present a request and hold it until accepted; returns just after the accept edge.
    task automatic issue(input bit id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        if (id) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = id ? (gnt1 === 1'b1) : (gnt0 === 1'b1);
        end
        chk("issue_accepted", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        repeat (n) @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        int cnt;
        bit got, p0, p1, a0, a1;
        reset = 1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        r3_req = 0; r3_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Idle after reset.
        repeat (5) begin
            @(negedge clk);
            chk("idle_gnt0", 32'(gnt0), 32'd0);
            chk("idle_gnt1", 32'(gnt1), 32'd0);
            chk("idle_wren_b", 32'(wren_b), 32'd0);
            chk("idle_address_b", 32'(address_b), 32'd0);
            chk("idle_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        end

        // Single read by requester 0 of preloaded 0xBEEF.
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        @(negedge clk);
        chk("rd0_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1;
        req0 = 0;
        for (int j = 0; j <= READ_LAT + 2; j++) begin
            @(negedge clk);
            if (j == 0) chk("rd0_address_b", 32'(address_b), 32'h0010);
            chk("rd0_rvalid0", 32'(rvalid0), 32'(j == READ_LAT + 1));
            if (j == READ_LAT + 1) chk("rd0_rdata", 32'(rdata), 32'hBEEF);
        end

        // Requester 1 write then back-to-back read of the same address.
        issue(1, 1, 16'h0200, 16'h1234);
        we1 = 0; wdata1 = '0;
        @(negedge clk);
        chk("wr1_wren_b", 32'(wren_b), 32'd1);
        chk("wr1_data_b", 32'(data_b), 32'h1234);
        chk("rd1_gnt1", 32'(gnt1), 32'd1);
        @(posedge clk); #1;
        req1 = 0;
        cnt = 0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) chk("rd1_wren_b", 32'(wren_b), 32'd0);
            if (rvalid1 === 1'b1) begin
                cnt++;
                got = 1;
                chk("rd1_rdata", 32'(rdata), 32'h1234);
            end
        end
        chk("rd1_pulses", 32'(cnt), 32'd1);

        // Both requesting continuously: strict alternation starting with requester 0.
        @(posedge clk); #1;
        do_reset(2);
        req0 = 1; we0 = 0; addr0 = 16'h0100;
        req1 = 1; we1 = 0; addr1 = 16'h0300;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("alt_one_grant", 32'(gnt0 ^ gnt1), 32'd1);
            chk("alt_gnt1", 32'(gnt1), 32'(c % 2));
            a0 = gnt0;
            @(posedge clk); #1;
            if (a0) addr0 = addr0 + 1'b1; else addr1 = addr1 + 1'b1;
        end
        req0 = 0; req1 = 0;
        repeat (READ_LAT + 3) @(posedge clk);
        #1;

        // Reset one cycle after a read accept discards it; held requests restart fresh.
        do_reset(1);
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1;
        reset = 1;
        req0 = 1; addr0 = 16'h0020; req1 = 1; we1 = 0; addr1 = 16'h0040;
        cnt = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rvalid0 === 1'b1) cnt++;
            chk("rst_no_gnt", 32'({gnt0, gnt1}), 32'd0);
            @(posedge clk); #1;
        end
        reset = 0;
        @(negedge clk);
        chk("rst_first_gnt0", 32'(gnt0), 32'd1);
        chk("rst_first_gnt1", 32'(gnt1), 32'd0);
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        chk("rst_then_gnt1", 32'(gnt1), 32'd1);
        @(posedge clk); #1;
        req1 = 0;
        for (int k = 0; k < READ_LAT + 3; k++) begin
            @(negedge clk);
            if (rvalid0 === 1'b1 && rdata === 16'hBEEF) cnt++;
        end
        chk("rst_discarded_reads", 32'(cnt), 32'd0);

        // READ_LAT=3 instance: return exactly four edges after accept.
        @(posedge clk); #1;
        r3_req = 1; r3_addr = 16'h0055;
        @(negedge clk);
        chk("lat3_gnt1", 32'(g1_3), 32'd1);
        @(posedge clk); #1;
        r3_req = 0;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            chk("lat3_rvalid1", 32'(rv1_3), 32'(j == 4));
            chk("lat3_rvalid0", 32'(rv0_3), 32'd0);
            chk("lat3_no_write", 32'({wren_3, g0_3}), 32'd0);
            if (j == 0) chk("lat3_address_b", 32'(addr_3), 32'h0055);
            if (j == 4) chk("lat3_rdata", 32'(rdata_3), 32'hA5F0);
        end
        chk("lat3_data_b", 32'(data_3), 32'd0);

        // Randomized traffic with occasional reset; the model checks every cycle.
        @(posedge clk); #1;
        p0 = 0; p1 = 0; a0 = 0; a1 = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (a0) begin p0 = 0; req0 = 0; end
            if (a1) begin p1 = 0; req1 = 0; end
            reset = ($urandom_range(0, 299) == 0);
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; req0 = 1; we0 = ($urandom_range(0, 7) == 0);
                addr0 = AW'($urandom_range(0, 31)); wdata0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; req1 = 1; we1 = $urandom_range(0, 1) == 1;
                addr1 = AW'($urandom_range(0, 31)); wdata1 = DW'($urandom);
            end
            @(negedge clk);
            a0 = (gnt0 === 1'b1);
            a1 = (gnt1 === 1'b1);
            @(posedge clk); #1;
        end
        reset = 0; req0 = 0; req1 = 0;
        repeat (READ_LAT + 4) @(posedge clk);
        #1;
        chk("drain_pending", 32'(pend.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
